cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 25 ++
 rtl/cpu_sequencer_if.sv | 26 ++
 rtl/cpu_sequencer_ack_watchdog.sv | 34 +++
 rtl/cpu_sequencer.sv | 108 ++++++++++
 tb/tb_cpu_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
package cpu_sequencer_pkg;

  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned WDOG_W      = 4;
  localparam int unsigned ACK_TIMEOUT = 15;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_ERROR
  } state_e;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer and the datapath/memory side.
interface cpu_sequencer_if;
  import cpu_sequencer_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ack;
  logic                mem_req;
  logic                mem_we;
  logic                addr_sel;
  logic                ir_load;
  logic                commit;
  logic                busy;
  logic                err;
  logic [COUNT_W-1:0]  instr_count;

  modport master (
    output run, opcode, mem_ack,
    input  mem_req, mem_we, addr_sel, ir_load, commit, busy, err, instr_count
  );

  modport slave (
    input  run, opcode, mem_ack,
    output mem_req, mem_we, addr_sel, ir_load, commit, busy, err, instr_count
  );
endinterface

// File: rtl/cpu_sequencer_ack_watchdog.sv
// Counts request cycles without an ack; flags expiry on the last allowed cycle.
module ack_watchdog
  import cpu_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // Expiry fires in the cycle that would be the ACK_TIMEOUT-th unanswered one.
  assign expired = tick && (cnt_q == WDOG_W'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && !expired) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, optional memory access, execute.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  cpu_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic               store_q, store_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;

  logic mem_req_c, mem_we_c, addr_sel_c, ir_load_c, commit_c, busy_c, err_c;
  logic wd_clear, wd_tick, wd_expired;

  // Watchdog sits at zero outside request states, so it is clear on every entry.
  assign wd_clear = !((state_q == ST_FETCH) || (state_q == ST_MEM));

  ack_watchdog u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    instr_count_d = instr_count_q;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    addr_sel_c    = 1'b0;
    ir_load_c     = 1'b0;
    commit_c      = 1'b0;
    busy_c        = 1'b1;
    err_c         = 1'b0;
    wd_tick       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          ir_load_c = 1'b1;
          state_d   = ST_DECODE;
        end else begin
          wd_tick = 1'b1;
          if (wd_expired) state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        // Direction is captured here so mem_we cannot move while MEM is pending.
        store_d = (bus.opcode == OP_STORE);
        state_d = is_mem_op(bus.opcode) ? ST_MEM : ST_EXEC;
      end
      ST_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = store_q;
        if (bus.mem_ack) begin
          state_d = ST_EXEC;
        end else begin
          wd_tick = 1'b1;
          if (wd_expired) state_d = ST_ERROR;
        end
      end
      ST_EXEC: begin
        commit_c      = 1'b1;
        instr_count_d = instr_count_q + COUNT_W'(1);
        state_d       = bus.run ? ST_FETCH : ST_IDLE;
      end
      ST_ERROR: begin
        busy_c = 1'b0;
        err_c  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      store_q       <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.mem_req     = mem_req_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.addr_sel    = addr_sel_c;
  assign bus.ir_load     = ir_load_c;
  assign bus.commit      = commit_c;
  assign bus.busy        = busy_c;
  assign bus.err         = err_c;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed and randomized checks of cpu_sequencer against a per-instruction timing model.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_count;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mem_op(input logic [3:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

  // Cycles from the first fetch cycle to the commit cycle, inclusive.
  function automatic int exp_latency(input logic [3:0] op, input int fd, input int md);
    return fd + 3 + (mem_op(op) ? md + 1 : 0);
  endfunction

  // Entered at the negedge of the first FETCH cycle; returns at the negedge after EXEC.
  task automatic exec_instr(input logic [3:0] op, input int fd, input int md,
                            input int drop_at, input string tag);
    int cyc, ph, ph_len, pc_n, ea_n, we_n, irl_n, irl_at, cmt_at, busy_low;
    bit was_req, ack;
    cyc = 0; ph = 0; ph_len = 0; pc_n = 0; ea_n = 0; we_n = 0;
    irl_n = 0; irl_at = -1; cmt_at = -1; busy_low = 0; was_req = 1'b0;
    bus.opcode = op;
    while (cmt_at < 0 && cyc < 60) begin
      cyc++;
      if (!bus.busy) busy_low++;
      if (bus.commit) cmt_at = cyc;
      if (bus.mem_req) begin
        ph_len++;
        if (bus.addr_sel) ea_n++; else pc_n++;
        if (bus.mem_we) we_n++;
        ack = (ph_len == ((ph == 0) ? fd + 1 : md + 1));
      end else begin
        if (was_req) begin
          ph++;
          ph_len = 0;
        end
        ack = ($urandom_range(0, 3) == 0);
      end
      was_req     = bus.mem_req;
      bus.mem_ack = ack;
      if (cyc == drop_at) bus.run = 1'b0;
      #1;
      if (bus.ir_load) begin
        irl_n++;
        irl_at = cyc;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    exp_count   = exp_count + 16'd1;
    chk({tag, " commit_cycle"}, 32'(cmt_at), 32'(exp_latency(op, fd, md)));
    chk({tag, " pc_req_cycles"}, 32'(pc_n), 32'(fd + 1));
    chk({tag, " ea_req_cycles"}, 32'(ea_n), 32'(mem_op(op) ? md + 1 : 0));
    chk({tag, " we_cycles"}, 32'(we_n), 32'((op == 4'hE) ? md + 1 : 0));
    chk({tag, " ir_load_count"}, 32'(irl_n), 32'd1);
    chk({tag, " ir_load_cycle"}, 32'(irl_at), 32'(fd + 1));
    chk({tag, " busy_low"}, 32'(busy_low), 32'd0);
    chk({tag, " commit_after"}, 32'(bus.commit), 32'd0);
    chk({tag, " instr_count"}, 32'(bus.instr_count), 32'(exp_count));
    chk({tag, " err"}, 32'(bus.err), 32'd0);
    if (drop_at > 0) begin
      chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " idle_req"}, 32'(bus.mem_req), 32'd0);
    end else begin
      chk({tag, " next_fetch_req"}, 32'(bus.mem_req), 32'd1);
      chk({tag, " next_fetch_sel"}, 32'(bus.addr_sel), 32'd0);
    end
  endtask

  initial begin
    bit idle;
    int n;
    bit seen_commit;
    logic [3:0] op;
    int fd, md, drop;

    total = 0; bad = 0; exp_count = 16'd0;
    rst_n = 1'b0;
    bus.run = 1'b1; bus.opcode = 4'h0; bus.mem_ack = 1'b1;

    // Reset holds everything quiet even with run and a stray ack present.
    repeat (2) @(negedge clk);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst ir_load", 32'(bus.ir_load), 32'd0);
    chk("rst commit", 32'(bus.commit), 32'd0);
    chk("rst count", 32'(bus.instr_count), 32'd0);
    bus.mem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("no fetch before edge", 32'(bus.mem_req), 32'd0);
    @(negedge clk);

    exec_instr(4'h1, 0, 0, 0, "alu0");
    exec_instr(4'hE, 0, 0, 0, "store0");
    exec_instr(4'hD, 0, 0, 0, "load0");
    exec_instr(4'h3, 5, 0, 0, "fetch_wait5");
    exec_instr(4'hD, 0, 14, 0, "mem_ack_at_15");
    exec_instr(4'h2, 0, 0, 2, "drop_in_decode");

    // Stray acks while idle must not start anything.
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle stray ack req", 32'(bus.mem_req), 32'd0);
    chk("idle stray ack busy", 32'(bus.busy), 32'd0);
    chk("idle stray ack count", 32'(bus.instr_count), 32'(exp_count));
    bus.mem_ack = 1'b0;

    idle = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op   = 4'($urandom_range(0, 15));
      fd   = int'($urandom_range(0, 4));
      md   = int'($urandom_range(0, 14));
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, exp_latency(op, fd, md))) : 0;
      if (idle) begin
        bus.run = 1'b1;
        @(negedge clk);
      end
      exec_instr(op, fd, md, drop, "rand");
      idle = (drop > 0);
    end
    if (!idle) exec_instr(4'h5, 0, 0, 1, "stop");

    // Unanswered memory request escalates to ERROR after 15 cycles.
    bus.opcode = 4'hD;
    bus.run    = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    n = 0; seen_commit = 1'b0;
    for (int i = 0; i < 40 && !bus.err; i++) begin
      if (bus.mem_req) n++;
      if (bus.commit) seen_commit = 1'b1;
      @(negedge clk);
    end
    chk("timeout req_cycles", 32'(n), 32'd15);
    chk("timeout err", 32'(bus.err), 32'd1);
    chk("timeout busy", 32'(bus.busy), 32'd0);
    chk("timeout no commit", 32'(seen_commit), 32'd0);
    chk("timeout count", 32'(bus.instr_count), 32'(exp_count));
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("error sticky", 32'(bus.err), 32'd1);
    chk("error no req", 32'(bus.mem_req), 32'd0);
    bus.mem_ack = 1'b0;

    bus.run = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("reset clears err", 32'(bus.err), 32'd0);
    chk("reset clears count", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    chk("post reset idle", 32'(bus.busy), 32'd0);
    bus.run = 1'b1;
    @(negedge clk);
    exec_instr(4'hE, 1, 2, 0, "after_error");

    // Reset asserted while a fetch is pending drops the request at once.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreq reset req", 32'(bus.mem_req), 32'd0);
    chk("midreq reset busy", 32'(bus.busy), 32'd0);
    chk("midreq reset count", 32'(bus.instr_count), 32'd0);
    bus.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    @(negedge clk);

    // Counter wrap from all-ones.
    force dut.instr_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.instr_count_q;
    @(negedge clk);
    exp_count = 16'hFFFF;
    chk("preload count", 32'(bus.instr_count), 32'hFFFF);
    bus.run = 1'b1;
    @(negedge clk);
    exec_instr(4'h7, 0, 0, 1, "wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
